// File: rtl/fp_denormalizer_if.sv
// rtl/fp_denormalizer_if.sv - operand/result handshake bundle for fp_denormalizer
//
// Purpose: groups the input operand channel and the output result channel
//   of the denormalizer into a single interface.
// Signals:
//   in_valid_i    operand valid (producer -> block)
//   in_ready_o    block can accept an operand
//   norm_data_i   normalized mantissa, WIDTH bits
//   leading_bit_i original leading-one position, POS_W bits
//   out_valid_o   result valid
//   out_ready_i   consumer accepts the result
//   denorm_data_o restored data, WIDTH bits
//   inexact_o     one or more 1-bits were shifted out
//   norm_err_o    operand nonzero but its MSB was 0
//   zero_o        operand was all zeros
// Modports: slave = block side, master = producer/consumer side.
interface fp_denormalizer_if #(
  parameter int WIDTH = 16,
  parameter int POS_W = $clog2(WIDTH)
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] norm_data_i;
  logic [POS_W-1:0] leading_bit_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] denorm_data_o;
  logic             inexact_o;
  logic             norm_err_o;
  logic             zero_o;

  modport slave (
    input  in_valid_i, norm_data_i, leading_bit_i, out_ready_i,
    output in_ready_o, out_valid_o, denorm_data_o, inexact_o, norm_err_o, zero_o
  );

  modport master (
    output in_valid_i, norm_data_i, leading_bit_i, out_ready_i,
    input  in_ready_o, out_valid_o, denorm_data_o, inexact_o, norm_err_o, zero_o
  );
endinterface

// File: rtl/fp_denormalizer.sv
// rtl/fp_denormalizer.sv - iterative right-shifter restoring a normalized mantissa
//
// Purpose: takes a left-justified mantissa plus the leading-one position the
//   normalizer reported and shifts it right by WIDTH-1-leading_bit, one bit
//   per cycle, flagging any 1-bits lost on the way.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   synchronous active-high reset
//   bus  slave modport of fp_denormalizer_if (operand in, result out)
module fp_denormalizer #(
  parameter int WIDTH = 16,
  parameter int POS_W = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  fp_denormalizer_if.slave     bus
);

  localparam logic [POS_W-1:0] MAX_POS = POS_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [POS_W-1:0] r_cnt;
  logic             r_inexact;
  logic             r_norm_err;
  logic             r_zero;
  logic             r_in_ready;
  logic             r_out_valid;

  // Shift distance; WIDTH-1 always fits in POS_W bits, so no wrap.
  logic [POS_W-1:0] w_shift;
  assign w_shift = MAX_POS - bus.leading_bit_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_data      <= '0;
      r_cnt       <= '0;
      r_inexact   <= 1'b0;
      r_norm_err  <= 1'b0;
      r_zero      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid_i) begin
            r_data     <= bus.norm_data_i;
            r_cnt      <= w_shift;
            r_zero     <= (bus.norm_data_i == '0);
            r_norm_err <= (bus.norm_data_i != '0) && !bus.norm_data_i[WIDTH-1];
            r_inexact  <= 1'b0;
            r_in_ready <= 1'b0;
            if (w_shift != '0) begin
              r_state <= ST_SHIFT;
            end else begin
              // Already aligned: result is ready the very next cycle.
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
            end
          end
        end

        ST_SHIFT: begin
          r_data    <= {1'b0, r_data[WIDTH-1:1]};
          r_inexact <= r_inexact | r_data[0];
          r_cnt     <= r_cnt - POS_W'(1);
          if (r_cnt == POS_W'(1)) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end
        end

        ST_DONE: begin
          // No accept on the release edge: in_ready rises only once back in IDLE.
          if (bus.out_ready_i) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready_o    = r_in_ready;
  assign bus.out_valid_o   = r_out_valid;
  assign bus.denorm_data_o = r_data;
  assign bus.inexact_o     = r_inexact;
  assign bus.norm_err_o    = r_norm_err;
  assign bus.zero_o        = r_zero;

endmodule

// File: tb/tb_fp_denormalizer.sv
// tb/tb_fp_denormalizer.sv - self-checking bench for fp_denormalizer
module tb_fp_denormalizer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_denormalizer_if #(.WIDTH(16)) bus ();

  fp_denormalizer #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic [15:0] data;
    logic [3:0]  pos;
    logic [15:0] exp_out;
    logic        exp_inexact;
    logic        exp_err;
    logic        exp_zero;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  // Applies one operand, waits for the result, captures it and releases it.
  task automatic run_op(input logic [15:0] d, input logic [3:0] p,
                        output logic [15:0] o, output logic ix, output logic er,
                        output logic zr, output int lat);
    chk("in_ready_before_op", 32'(bus.in_ready_o), 32'd1);
    bus.norm_data_i   = d;
    bus.leading_bit_i = p;
    bus.in_valid_i    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    lat = 0;
    while (!bus.out_valid_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid_o) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: out_valid never rose for data 0x%0h pos %0d", d, p);
    end
    o  = bus.denorm_data_o;
    ix = bus.inexact_o;
    er = bus.norm_err_o;
    zr = bus.zero_o;
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
  endtask

  // Reference: plain arithmetic on the shift rules.
  task automatic ref_model(input logic [15:0] d, input logic [3:0] p,
                           output logic [15:0] o, output logic ix, output logic er,
                           output logic zr, output int lat);
    int s;
    logic [15:0] mask;
    s    = 15 - int'(p);
    mask = 16'((32'd1 << s) - 1);
    o    = d >> s;
    ix   = (d & mask) != 0;
    er   = (d != 0) && (d < 16'h8000);
    zr   = (d == 0);
    lat  = s;
  endtask

  initial begin
    logic [15:0] o, eo, x, nd;
    logic ix, er, zr, eix, eer, ezr;
    int lat, elat, p, seen;

    vecs[0] = '{16'hC006, 4'd14, 16'h6003, 1'b0, 1'b0, 1'b0, 1};
    vecs[1] = '{16'h8000, 4'd0,  16'h0001, 1'b0, 1'b0, 1'b0, 15};
    vecs[2] = '{16'h8000, 4'd15, 16'h8000, 1'b0, 1'b0, 1'b0, 0};
    vecs[3] = '{16'hC007, 4'd14, 16'h6003, 1'b1, 1'b0, 1'b0, 1};
    vecs[4] = '{16'h4000, 4'd15, 16'h4000, 1'b0, 1'b1, 1'b0, 0};
    vecs[5] = '{16'h0000, 4'd3,  16'h0000, 1'b0, 1'b0, 1'b1, 12};
    vecs[6] = '{16'hFFFF, 4'd8,  16'h01FF, 1'b1, 1'b0, 1'b0, 7};
    vecs[7] = '{16'h8001, 4'd4,  16'h0010, 1'b1, 1'b0, 1'b0, 11};

    bus.in_valid_i    = 1'b0;
    bus.norm_data_i   = '0;
    bus.leading_bit_i = '0;
    bus.out_ready_i   = 1'b0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(bus.in_ready_o), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("reset_data", 32'(bus.denorm_data_o), 32'd0);
    chk("reset_flags", {29'd0, bus.inexact_o, bus.norm_err_o, bus.zero_o}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].data, vecs[i].pos, o, ix, er, zr, lat);
      chk($sformatf("vec%0d_out", i), 32'(o), 32'(vecs[i].exp_out));
      chk($sformatf("vec%0d_inexact", i), 32'(ix), 32'(vecs[i].exp_inexact));
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_zero", i), 32'(zr), 32'(vecs[i].exp_zero));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Backpressure: 0xC000 at pos 13 restores to 0x3000 after 2 shifts.
    bus.norm_data_i   = 16'hC000;
    bus.leading_bit_i = 4'd13;
    bus.in_valid_i    = 1'b1;
    @(posedge clk); #1;
    bus.norm_data_i   = 16'h8000;
    bus.leading_bit_i = 4'd15;
    lat = 0;
    while (!bus.out_valid_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_latency", 32'(lat), 32'd2);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(bus.out_valid_o), 32'd1);
      chk("bp_hold_data", 32'(bus.denorm_data_o), 32'h3000);
      chk("bp_hold_in_ready", 32'(bus.in_ready_o), 32'd0);
    end
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    chk("bp_release_valid", 32'(bus.out_valid_o), 32'd0);
    chk("bp_release_in_ready", 32'(bus.in_ready_o), 32'd1);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    chk("bp_next_valid", 32'(bus.out_valid_o), 32'd1);
    chk("bp_next_data", 32'(bus.denorm_data_o), 32'h8000);
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;

    // Reset during the fifth shift cycle discards the operand.
    bus.norm_data_i   = 16'h8000;
    bus.leading_bit_i = 4'd0;
    bus.in_valid_i    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", 32'(bus.in_ready_o), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("midrst_flags", {29'd0, bus.inexact_o, bus.norm_err_o, bus.zero_o}, 32'd0);
    chk("midrst_data", 32'(bus.denorm_data_o), 32'd0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid_o) seen++;
    end
    chk("midrst_no_result", 32'(seen), 32'd0);

    // Round trip through an ideal normalizer.
    for (int n = 0; n < 1000; n++) begin
      x = 16'($urandom_range(16'hFFFF, 1));
      p = 0;
      for (int b = 0; b < 16; b++) if (x[b]) p = b;
      nd = x << (15 - p);
      run_op(nd, 4'(p), o, ix, er, zr, lat);
      chk("rt_out", 32'(o), 32'(x));
      chk("rt_inexact", 32'(ix), 32'd0);
      chk("rt_err", 32'(er), 32'd0);
      chk("rt_latency", 32'(lat), 32'(15 - p));
    end

    // Arbitrary operands, including non-normalized ones.
    for (int n = 0; n < 200; n++) begin
      x = 16'($urandom);
      if (n % 8 == 0) x = '0;
      p = int'($urandom_range(15, 0));
      ref_model(x, 4'(p), eo, eix, eer, ezr, elat);
      run_op(x, 4'(p), o, ix, er, zr, lat);
      chk("rnd_out", 32'(o), 32'(eo));
      chk("rnd_inexact", 32'(ix), 32'(eix));
      chk("rnd_err", 32'(er), 32'(eer));
      chk("rnd_zero", 32'(zr), 32'(ezr));
      chk("rnd_latency", 32'(lat), 32'(elat));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
